// File: rtl/blood_match_scanner.sv
// Walks the four blood types as candidate partners of one latched type and
// accumulates which of them are compatible, slowed by STEP_CYCLES per candidate.
module blood_match_scanner #(
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [1:0] type_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] cur_type,
    output logic       cur_match,
    output logic [3:0] match_mask,
    output logic [2:0] match_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEP_CYCLES - 1);
    localparam logic [1:0]       TYPE_O    = 2'b01;
    localparam logic [1:0]       TYPE_AB   = 2'b11;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       cur_type_nxt;
    logic [3:0]       mask_nxt;
    logic [2:0]       count_nxt;
    logic             lat_mode, lat_mode_nxt;
    logic [1:0]       lat_type, lat_type_nxt;

    // Donor d may give to recipient r.
    function automatic logic compat(input logic [1:0] d, input logic [1:0] r);
        return (d == TYPE_O) || (r == TYPE_AB) || (d == r);
    endfunction

    // mode 0: latched type is the recipient; mode 1: latched type is the donor.
    assign cur_match = lat_mode ? compat(lat_type, cur_type) : compat(cur_type, lat_type);
    assign busy      = (state == SCAN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_type    <= '0;
            match_mask  <= '0;
            match_count <= '0;
            lat_mode    <= 1'b0;
            lat_type    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cur_type    <= cur_type_nxt;
            match_mask  <= mask_nxt;
            match_count <= count_nxt;
            lat_mode    <= lat_mode_nxt;
            lat_type    <= lat_type_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_type_nxt = cur_type;
        mask_nxt     = match_mask;
        count_nxt    = match_count;
        lat_mode_nxt = lat_mode;
        lat_type_nxt = lat_type;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    lat_mode_nxt = mode;
                    lat_type_nxt = type_in;
                    mask_nxt     = '0;
                    count_nxt    = '0;
                    cur_type_nxt = '0;
                    cnt_nxt      = '0;
                    state_nxt    = SCAN;
                end
            end
            SCAN: begin
                if (cnt == LAST_STEP) begin
                    mask_nxt[cur_type] = cur_match;
                    count_nxt          = match_count + {2'b00, cur_match};
                    cnt_nxt            = '0;
                    if (cur_type == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        cur_type_nxt = cur_type + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_blood_match_scanner.sv
// Bench for blood_match_scanner: instance 0 uses STEP_CYCLES=1, instance 1 uses 3.
module tb_blood_match_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s[2];
    logic       start_s[2];
    logic       mode_s[2];
    logic [1:0] type_s[2];
    logic       busy_s[2];
    logic       done_s[2];
    logic [1:0] cur_type_s[2];
    logic       cur_match_s[2];
    logic [3:0] mask_s[2];
    logic [2:0] count_s[2];

    logic [6:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    blood_match_scanner #(.STEP_CYCLES(1), .CNT_W(27)) dut_fast (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .mode(mode_s[0]), .type_in(type_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .cur_type(cur_type_s[0]), .cur_match(cur_match_s[0]),
        .match_mask(mask_s[0]), .match_count(count_s[0])
    );

    blood_match_scanner #(.STEP_CYCLES(3), .CNT_W(4)) dut_slow (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .mode(mode_s[1]), .type_in(type_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .cur_type(cur_type_s[1]), .cur_match(cur_match_s[1]),
        .match_mask(mask_s[1]), .match_count(count_s[1])
    );

    // Runs one scan from IDLE or DONE and checks entry, latency and result.
    task automatic run_scan(input int d, input logic m, input logic [1:0] t,
                            input logic [3:0] em, input logic [2:0] ec);
        int steps;
        int n;
        logic [6:0] exp;
        steps = (d == 1) ? 3 : 1;
        exp_q.push_back({em, ec});
        mode_s[d] = m;
        type_s[d] = t;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        n_vec++;
        if (busy_s[d] !== 1'b1 || done_s[d] !== 1'b0 || cur_type_s[d] !== 2'd0 ||
            mask_s[d] !== 4'd0 || count_s[d] !== 3'd0) begin
            n_err++;
            $display("FAIL scan_entry d=%0d: busy=%b done=%b cur=%0d mask=%b cnt=%0d, want 1 0 0 0000 0",
                     d, busy_s[d], done_s[d], cur_type_s[d], mask_s[d], count_s[d]);
        end
        n = 0;
        while (done_s[d] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (n != 4 * steps) begin
            n_err++;
            $display("FAIL scan_latency d=%0d: %0d cycles, want %0d", d, n, 4 * steps);
        end
        exp = exp_q.pop_front();
        n_vec++;
        if ({mask_s[d], count_s[d]} !== exp || busy_s[d] !== 1'b0 || cur_type_s[d] !== 2'd3) begin
            n_err++;
            $display("FAIL scan_result d=%0d m=%b t=%b: mask=%b cnt=%0d busy=%b cur=%0d, want mask=%b cnt=%0d busy=0 cur=3",
                     d, m, t, mask_s[d], count_s[d], busy_s[d], cur_type_s[d], exp[6:3], exp[2:0]);
        end
    endtask

    task automatic test_reset();
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            // Latched A vs candidate A: compatible straight out of reset.
            if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || cur_type_s[d] !== 2'd0 ||
                mask_s[d] !== 4'd0 || count_s[d] !== 3'd0 || cur_match_s[d] !== 1'b1) begin
                n_err++;
                $display("FAIL reset d=%0d: busy=%b done=%b cur=%0d mask=%b cnt=%0d match=%b, want 0 0 0 0000 0 1",
                         d, busy_s[d], done_s[d], cur_type_s[d], mask_s[d], count_s[d], cur_match_s[d]);
            end
        end
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    endtask

    task automatic test_recipient();
        run_scan(0, 1'b0, 2'b11, 4'b1111, 3'd4);
        run_scan(0, 1'b0, 2'b01, 4'b0010, 3'd1);
        run_scan(0, 1'b0, 2'b00, 4'b0011, 3'd2);
    endtask

    task automatic test_donor();
        run_scan(0, 1'b1, 2'b01, 4'b1111, 3'd4);
        run_scan(0, 1'b1, 2'b10, 4'b1100, 3'd2);
        run_scan(0, 1'b1, 2'b11, 4'b1000, 3'd1);
    endtask

    task automatic test_slow_step();
        logic [6:0] exp;
        exp_q.push_back({4'b0110, 3'd2});
        mode_s[1] = 1'b0; type_s[1] = 2'b10; start_s[1] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (cur_type_s[1] !== 2'(i / 3) || busy_s[1] !== 1'b1) begin
                n_err++;
                $display("FAIL slow_walk i=%0d: cur=%0d busy=%b, want cur=%0d busy=1",
                         i, cur_type_s[1], busy_s[1], i / 3);
            end
            start_s[1] = (i == 11) ? 1'b0 : 1'($urandom_range(0, 1));
            mode_s[1]  = 1'($urandom_range(0, 1));
            type_s[1]  = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (done_s[1] !== 1'b1 || {mask_s[1], count_s[1]} !== exp) begin
            n_err++;
            $display("FAIL slow_result: done=%b mask=%b cnt=%0d, want done=1 mask=%b cnt=%0d",
                     done_s[1], mask_s[1], count_s[1], exp[6:3], exp[2:0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_q.push_back({4'b1111, 3'd4});
        mode_s[0] = 1'b0; type_s[0] = 2'b11; start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++;
        if (cur_type_s[0] !== 2'd2 || busy_s[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort: cur=%0d busy=%b, want cur=2 busy=1", cur_type_s[0], busy_s[0]);
        end
        rst_s[0] = 1'b1;
        @(posedge clk); #1;
        rst_s[0] = 1'b0;
        void'(exp_q.pop_back());
        n_vec++;
        if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 || mask_s[0] !== 4'd0 ||
            count_s[0] !== 3'd0 || cur_type_s[0] !== 2'd0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b mask=%b cnt=%0d cur=%0d, want 0 0 0000 0 0",
                     busy_s[0], done_s[0], mask_s[0], count_s[0], cur_type_s[0]);
        end
        @(posedge clk); #1;
        n_vec++;
        if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: busy=%b done=%b, want 0 0", busy_s[0], done_s[0]);
        end
        run_scan(0, 1'b0, 2'b10, 4'b0110, 3'd2);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [6:0] exp;
        // From DONE, restart immediately with a new query.
        run_scan(0, 1'b1, 2'b00, 4'b1001, 3'd2);
        // Held start: re-scans with one DONE cycle in between.
        exp_q.push_back({4'b0010, 3'd1});
        exp_q.push_back({4'b0010, 3'd1});
        mode_s[0] = 1'b0; type_s[0] = 2'b01; start_s[0] = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            n = 0;
            while (done_s[0] !== 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            exp = exp_q.pop_front();
            n_vec++;
            if (n != 4 || {mask_s[0], count_s[0]} !== exp) begin
                n_err++;
                $display("FAIL held_scan s=%0d: cycles=%0d mask=%b cnt=%0d, want 4 %b %0d",
                         s, n, mask_s[0], count_s[0], exp[6:3], exp[2:0]);
            end
            if (s == 1) start_s[0] = 1'b0;
            @(posedge clk); #1;
            n_vec++;
            if (s == 0 && (busy_s[0] !== 1'b1 || done_s[0] !== 1'b0)) begin
                n_err++;
                $display("FAIL held_restart: busy=%b done=%b, want 1 0", busy_s[0], done_s[0]);
            end else if (s == 1 && (busy_s[0] !== 1'b0 || done_s[0] !== 1'b1 || mask_s[0] !== 4'b0010)) begin
                n_err++;
                $display("FAIL done_hold: busy=%b done=%b mask=%b, want 0 1 0010",
                         busy_s[0], done_s[0], mask_s[0]);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; start_s[d] = 1'b0; mode_s[d] = 1'b0; type_s[d] = 2'b00;
        end
        test_reset();
        test_recipient();
        test_donor();
        test_slow_step();
        test_reset_mid_scan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blood_match_scanner.md
Name: blood_match_scanner

Overview:
- Sequential companion to the board's combinational blood-type compatibility checker, which answers yes/no for one donor/recipient pair.
- This block runs the query in the other direction. Given one blood type and a direction, it steps through all four partner types and reports which of them are compatible. It also reports how many are compatible.
- It sits between the EGO1 switch/button inputs and the LED outputs. STEP_CYCLES slows the walk so that it is visible on the LEDs.
- Type encoding, shared with the checker: 2'b00=A, 2'b01=O, 2'b10=B, 2'b11=AB.

Parameters:
- STEP_CYCLES, 1, number of clock cycles spent on each candidate type. Legal range is 1 or more.
- CNT_W, 27, width of the internal step counter. It must satisfy 2^CNT_W >= STEP_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  level, sampled every cycle. Starts a scan when the block is in IDLE or DONE.
- mode  input  1  0 = type_in is the recipient; find compatible donors. 1 = type_in is the donor; find compatible recipients.
- type_in  input  2  given blood type.
- busy  output  1  high while in SCAN.
- done  output  1  high while in DONE.
- cur_type  output  2  candidate type currently being evaluated.
- cur_match  output  1  compatibility of the latched type with cur_type. Combinational from registers.
- match_mask  output  4  bit i set means candidate type i is compatible.
- match_count  output  3  number of set bits in match_mask, range 0..4.

Behaviour:
- Compatibility rule, donor D to recipient R: compatible when any of the following holds:
  - D == O
  - R == AB
  - D == R
- mode=0: D = candidate, R = latched type. mode=1: D = latched type, R = candidate.
- Reset, synchronous:
  - state = IDLE.
  - busy, done, cur_type, match_mask, match_count, the step counter, the latched mode and the latched type all go to 0.
  - cur_match follows from these registers.
  - Reset overrides everything, including a reset asserted mid-scan. No partial results are held.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at edge k causes the following at that edge: latch mode and type_in; clear match_mask and match_count; cur_type = 0; counter = 0; state = SCAN.
- SCAN:
  - busy = 1.
  - Each cycle, if counter == STEP_CYCLES-1: set match_mask[cur_type] = cur_match, add cur_match to match_count, clear the counter, then:
    - if cur_type == 3, go to DONE;
    - otherwise increment cur_type.
  - If counter != STEP_CYCLES-1, increment the counter.
  - start, mode and type_in are ignored during SCAN. Only the latched values are used.
- DONE:
  - done = 1, busy = 0.
  - cur_type holds 3. match_mask and match_count hold the final result.
  - start = 1 restarts exactly as from IDLE: it latches, clears and enters SCAN at the same edge.
- Timing:
  - With start accepted at edge k, the last evaluation and the DONE entry both occur at edge k+4*STEP_CYCLES.
  - With STEP_CYCLES=1, the scan takes 4 cycles.
- Partial results: match_mask and match_count are updated incrementally during SCAN, so the LEDs show progress.
- start held high continuously: the block re-scans in every cycle it spends in DONE. done is high for one cycle between scans.
- No illegal states: an unused state encoding returns to IDLE on the next edge.

Test Plan:
- STEP_CYCLES=1, mode=0, type_in=11 (recipient AB), start pulse at edge k -> busy for 4 cycles; DONE at k+4; mask=1111, count=4.
- mode=0, type_in=01 (recipient O) -> mask=0010, count=1. Then mode=0, type_in=00 (recipient A) -> mask=0011, count=2.
- mode=1, type_in=01 (donor O) -> mask=1111, count=4. mode=1, type_in=10 (donor B) -> mask=1100, count=2. mode=1, type_in=11 (donor AB) -> mask=1000, count=1.
- STEP_CYCLES=3, mode=0, type_in=10 -> cur_type holds each value for 3 cycles; DONE at k+12; mask=0110, count=2. Toggling type_in, mode or start mid-scan does not change this result.
- Assert rst while cur_type=2 in SCAN -> next edge: state IDLE; busy=0, done=0, mask=0000, count=0, cur_type=0. A fresh start then completes normally.
- In DONE, start=1 with mode=1, type_in=00 -> re-enters SCAN at the same edge; final mask=1001, count=2.
